// File: rtl/uart_imem_loader_if.sv
// Handshake bundle between the UART byte stream, the instruction memory write port
// and the boot-status outputs of uart_imem_loader.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_en;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rstn;
  logic              write_done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    output load_en, rx_valid, rx_data, rx_break,
    input  imem_we, imem_addr, imem_wdata, core_rstn, write_done, overflow, word_count
  );

  modport slave (
    input  load_en, rx_valid, rx_data, rx_break,
    output imem_we, imem_addr, imem_wdata, core_rstn, write_done, overflow, word_count
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes little-endian into 32-bit words, writes them to IMEM and
// releases the core on a 0xFFFFFFFF terminator. Define LOADER_TIMEOUT_EN for the inter-byte timeout.
module uart_imem_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             resetn,
  uart_imem_loader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_write_done;
  logic              r_overflow;

  logic [31:0]       w_word;
  logic              w_last_addr;
  logic              w_restart;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_imem_loader: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;
`endif

  always_comb begin
    w_word = r_word;
    case (r_idx)
      2'd0:    w_word[7:0]   = bus.rx_data;
      2'd1:    w_word[15:8]  = bus.rx_data;
      2'd2:    w_word[23:16] = bus.rx_data;
      default: w_word[31:24] = bus.rx_data;
    endcase
  end

  assign w_last_addr = (r_addr == {ADDR_W{1'b1}});
  assign w_restart   = (r_state == S_IDLE) && bus.load_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_word       <= 32'd0;
      r_addr       <= '0;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_write_done <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_en) begin
            r_state <= S_LOAD;
            r_idx   <= 2'd0;
            r_word  <= 32'd0;
            r_addr  <= '0;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          if (!bus.load_en) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_word  <= 32'd0;
          end else if (bus.rx_break) begin
            // A break outranks a byte arriving in the same cycle.
            r_idx <= 2'd0;
          end else if (bus.rx_valid) begin
            r_word <= w_word;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (w_word == 32'hFFFF_FFFF) begin
                r_state      <= S_DONE;
                r_write_done <= 1'b1;
              end else begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
              end
            end
`ifdef LOADER_TIMEOUT_EN
          end else if (r_idx != 2'd0 && r_to_cnt == TO_LAST) begin
            r_idx <= 2'd0;
`endif
          end
        end
        default: ;
      endcase

      // Address and count advance at the end of the write-strobe cycle, so the
      // strobe sees a stable address; a restart into LOAD clears them instead.
      if (r_we && !w_restart) begin
        r_count <= r_count + 1'b1;
        if (!w_last_addr) begin
          r_addr <= r_addr + 1'b1;
        end else if (r_state == S_LOAD) begin
          r_overflow <= 1'b1;
          r_state    <= S_DONE;
        end
      end

`ifdef LOADER_TIMEOUT_EN
      if (r_state != S_LOAD || r_idx == 2'd0 || bus.rx_break || bus.rx_valid || r_to_cnt == TO_LAST) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
`endif
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_rstn  = r_write_done;
  assign bus.write_done = r_write_done;
  assign bus.overflow   = r_overflow;
  assign bus.word_count = r_count;

endmodule
